// File: rtl/pulse_train_meter_pkg.sv
// Shared types and helpers for the pulse train meter.
// Record layout, width constants, thermometer/popcount helpers.
package pulse_meter_pkg;

    localparam int WIDTH   = 8;
    localparam int CNT_W   = 8;
    localparam int THERM_W = 4;

    typedef struct packed {
        logic [CNT_W-1:0]   hi;
        logic [CNT_W-1:0]   lo;
        logic [THERM_W-1:0] therm;
        logic               bubble;
        logic               partial;
    } meter_rec_t;

    function automatic logic is_therm(
        input logic [WIDTH-1:0] word
    );
        logic [WIDTH-1:0] nxt;
        nxt = word + WIDTH'(1);
        return (word & nxt) == '0;
    endfunction

    function automatic logic [THERM_W-1:0] popcount(
        input logic [WIDTH-1:0] word
    );
        logic [THERM_W-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++)
            c = c + THERM_W'(word[i]);
        return c;
    endfunction

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/pulse_train_meter_if.sv
// Serial line, chain image and record handshake of the meter.
// slave faces the meter, master faces the line/consumer side.
interface pulse_train_meter_if;
    import pulse_meter_pkg::*;

    logic               sin;
    logic [WIDTH-1:0]   par_in;
    logic               rec_valid;
    logic               rec_ready;
    logic [CNT_W-1:0]   rec_hi;
    logic [CNT_W-1:0]   rec_lo;
    logic [THERM_W-1:0] rec_therm;
    logic               rec_bubble;
    logic               rec_partial;
    logic               ovf;

    modport slave (
        input  sin, par_in, rec_ready,
        output rec_valid, rec_hi, rec_lo,
        output rec_therm, rec_bubble,
        output rec_partial, ovf
    );

    modport master (
        output sin, par_in, rec_ready,
        input  rec_valid, rec_hi, rec_lo,
        input  rec_therm, rec_bubble,
        input  rec_partial, ovf
    );

endinterface

// File: rtl/pulse_train_meter_fifo.sv
// Two-entry in-order record buffer.
// A push into a full buffer survives only if the head leaves that cycle.
module meter_rec_fifo
    import pulse_meter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  meter_rec_t din,
    output meter_rec_t head,
    output logic       valid,
    output logic       ovf
);

    meter_rec_t mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       full;
    logic       empty;
    logic       do_pop;
    logic       do_push;

    assign full    = count == 2'd2;
    assign empty   = count == 2'd0;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++)
                mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            if (do_push & ~do_pop)
                count <= count + 2'd1;
            else if (do_pop & ~do_push)
                count <= count - 2'd1;
            if (push & full & ~do_pop)
                ovf <= 1'b1;
        end
    end

    assign valid = ~empty;
    assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/pulse_train_meter.sv
// Pulse train meter: edge detect, hi/lo run counters, record build.
// One record per high pulse, emitted at the falling edge.
module pulse_train_meter
    import pulse_meter_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    pulse_train_meter_if.slave bus
);

    logic             sin_q;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] lo_cnt;
    logic [CNT_W-1:0] lo_hold;
    logic             lo_part;
    logic             seen_fall;
    meter_rec_t       rec_new;
    meter_rec_t       head;
    logic             valid;
    logic             ovf;

    assign rise = ~sin_q & bus.sin;
    assign fall = sin_q & ~bus.sin;

    always_ff @(posedge clk) begin
        if (rst) begin
            sin_q     <= 1'b0;
            hi_cnt    <= '0;
            lo_cnt    <= '0;
            lo_hold   <= '0;
            lo_part   <= 1'b0;
            seen_fall <= 1'b0;
        end else begin
            sin_q <= bus.sin;
            if (rise)
                hi_cnt <= CNT_W'(1);
            else if (bus.sin)
                hi_cnt <= sat_inc(hi_cnt);
            if (fall)
                lo_cnt <= CNT_W'(1);
            else if (~bus.sin)
                lo_cnt <= sat_inc(lo_cnt);
            // Low run is frozen at the rise so it pairs with this pulse.
            if (rise) begin
                lo_hold <= lo_cnt;
                lo_part <= ~seen_fall;
            end
            if (fall)
                seen_fall <= 1'b1;
        end
    end

    assign rec_new.hi      = hi_cnt;
    assign rec_new.lo      = lo_hold;
    assign rec_new.therm   = popcount(bus.par_in);
    assign rec_new.bubble  = ~is_therm(bus.par_in);
    assign rec_new.partial = lo_part;

    meter_rec_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fall),
        .pop   (bus.rec_ready),
        .din   (rec_new),
        .head  (head),
        .valid (valid),
        .ovf   (ovf)
    );

    assign bus.rec_valid   = valid;
    assign bus.rec_hi      = head.hi;
    assign bus.rec_lo      = head.lo;
    assign bus.rec_therm   = head.therm;
    assign bus.rec_bubble  = head.bubble;
    assign bus.rec_partial = head.partial;
    assign bus.ovf         = ovf;

endmodule

// File: tb/tb_pulse_train_meter.sv
// Testbench for pulse_train_meter: directed and random pulse trains.
// Reference model derives records from the raw sample history.
module tb_pulse_train_meter;
    import pulse_meter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    pulse_train_meter_if bus ();

    pulse_train_meter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic       hist [$];
    meter_rec_t exp_q [$];
    logic       ovf_m;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    function automatic bit is_mask(input logic [7:0] p);
        for (int n = 0; n <= 8; n++)
            if (int'(p) == (1 << n) - 1) return 1'b1;
        return 1'b0;
    endfunction

    // Pulse just ended: count trailing ones, then the zeros before them.
    function automatic meter_rec_t model_rec(input logic [7:0] p);
        meter_rec_t r;
        int i, nh, nl;
        i  = hist.size() - 1;
        nh = 0;
        nl = 0;
        while (i >= 0 && hist[i] == 1'b1) begin nh++; i--; end
        while (i >= 0 && hist[i] == 1'b0) begin nl++; i--; end
        r.hi      = 8'((nh > 255) ? 255 : nh);
        r.lo      = 8'((nl > 255) ? 255 : nl);
        r.therm   = 4'($countones(p));
        r.bubble  = !is_mask(p);
        r.partial = (i < 0);
        return r;
    endfunction

    task automatic check_cycle(input string tag);
        chk({tag, "_valid"}, 32'(bus.rec_valid),
            32'(exp_q.size() > 0));
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'(ovf_m));
        if (exp_q.size() > 0) begin
            chk({tag, "_hi"}, 32'(bus.rec_hi), 32'(exp_q[0].hi));
            chk({tag, "_lo"}, 32'(bus.rec_lo), 32'(exp_q[0].lo));
            chk({tag, "_therm"}, 32'(bus.rec_therm),
                32'(exp_q[0].therm));
            chk({tag, "_bubble"}, 32'(bus.rec_bubble),
                32'(exp_q[0].bubble));
            chk({tag, "_partial"}, 32'(bus.rec_partial),
                32'(exp_q[0].partial));
        end
    endtask

    task automatic step(input logic s, input logic [7:0] p,
                        input logic rdy);
        logic       prev;
        bit         fall, pop, push_ok;
        meter_rec_t r;
        bus.sin       = s;
        bus.par_in    = p;
        bus.rec_ready = rdy;
        prev = (hist.size() > 0) ? hist[$] : 1'b0;
        fall = prev && !s;
        r    = '0;
        if (fall) r = model_rec(p);
        hist.push_back(s);
        pop = (exp_q.size() > 0) && rdy;
        @(posedge clk);
        #1;
        push_ok = fall && (exp_q.size() < 2 || pop);
        if (fall && !push_ok) ovf_m = 1'b1;
        if (pop) void'(exp_q.pop_front());
        if (push_ok) exp_q.push_back(r);
        check_cycle("cyc");
    endtask

    task automatic run(input logic s, input int n, input logic rdy);
        for (int k = 0; k < n; k++) step(s, 8'h00, rdy);
    endtask

    task automatic do_reset(input logic s);
        rst           = 1'b1;
        bus.sin       = s;
        bus.par_in    = 8'h00;
        bus.rec_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        hist.delete();
        exp_q.delete();
        ovf_m = 1'b0;
        chk("rst_valid", 32'(bus.rec_valid), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        chk("rst_hi", 32'(bus.rec_hi), 32'd0);
        chk("rst_lo", 32'(bus.rec_lo), 32'd0);
        chk("rst_therm", 32'(bus.rec_therm), 32'd0);
        chk("rst_flags",
            32'({bus.rec_bubble, bus.rec_partial}), 32'd0);
    endtask

    initial begin
        bus.sin       = 1'b0;
        bus.par_in    = 8'h00;
        bus.rec_ready = 1'b0;
        ovf_m         = 1'b0;

        // first record after reset
        do_reset(1'b0);
        run(1'b0, 4, 1'b0);
        run(1'b1, 3, 1'b0);
        step(1'b0, 8'h07, 1'b0);
        chk("t1_valid", 32'(bus.rec_valid), 32'd1);
        chk("t1_hi", 32'(bus.rec_hi), 32'd3);
        chk("t1_lo", 32'(bus.rec_lo), 32'd4);
        chk("t1_therm", 32'(bus.rec_therm), 32'd3);
        chk("t1_bubble", 32'(bus.rec_bubble), 32'd0);
        chk("t1_partial", 32'(bus.rec_partial), 32'd1);

        // second record, first popped
        run(1'b0, 4, 1'b1);
        chk("t2_empty", 32'(bus.rec_valid), 32'd0);
        run(1'b1, 2, 1'b1);
        step(1'b0, 8'h03, 1'b1);
        chk("t2_hi", 32'(bus.rec_hi), 32'd2);
        chk("t2_lo", 32'(bus.rec_lo), 32'd5);
        chk("t2_partial", 32'(bus.rec_partial), 32'd0);

        // bubble detection
        run(1'b0, 2, 1'b1);
        run(1'b1, 2, 1'b1);
        step(1'b0, 8'h05, 1'b1);
        chk("t3_therm5", 32'(bus.rec_therm), 32'd2);
        chk("t3_bubble5", 32'(bus.rec_bubble), 32'd1);
        run(1'b0, 2, 1'b1);
        run(1'b1, 2, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("t3_therm0", 32'(bus.rec_therm), 32'd0);
        chk("t3_bubble0", 32'(bus.rec_bubble), 32'd0);
        run(1'b0, 2, 1'b1);

        // overflow on third record
        for (int h = 1; h <= 3; h++) begin
            run(1'b1, h, 1'b0);
            step(1'b0, 8'h01, 1'b0);
            run(1'b0, 1, 1'b0);
        end
        chk("t4_ovf", 32'(bus.ovf), 32'd1);
        chk("t4_head1", 32'(bus.rec_hi), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        chk("t4_head2", 32'(bus.rec_hi), 32'd2);
        step(1'b0, 8'h00, 1'b1);
        chk("t4_drained", 32'(bus.rec_valid), 32'd0);
        chk("t4_ovf_sticky", 32'(bus.ovf), 32'd1);

        // full + fall + pop in the same cycle
        do_reset(1'b0);
        run(1'b0, 2, 1'b0);
        run(1'b1, 1, 1'b0);
        run(1'b0, 2, 1'b0);
        run(1'b1, 2, 1'b0);
        run(1'b0, 2, 1'b0);
        run(1'b1, 4, 1'b0);
        step(1'b0, 8'h0f, 1'b1);
        chk("t5_ovf", 32'(bus.ovf), 32'd0);
        chk("t5_head", 32'(bus.rec_hi), 32'd2);
        step(1'b0, 8'h00, 1'b1);
        chk("t5_last", 32'(bus.rec_hi), 32'd4);
        run(1'b0, 2, 1'b1);

        // saturation
        run(1'b1, 300, 1'b1);
        step(1'b0, 8'hff, 1'b0);
        chk("t5_sat_hi", 32'(bus.rec_hi), 32'd255);
        run(1'b0, 270, 1'b1);
        run(1'b1, 1, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        chk("t5_sat_lo", 32'(bus.rec_lo), 32'd255);

        // random trains with random back-pressure
        do_reset(1'b0);
        for (int n = 0; n < 60; n++) begin
            int          lo_len, hi_len;
            logic [7:0]  p;
            lo_len = $urandom_range(1, 12);
            hi_len = $urandom_range(1, 10);
            if ($urandom_range(0, 1) == 0)
                p = 8'((1 << $urandom_range(0, 8)) - 1);
            else
                p = 8'($urandom);
            for (int k = 0; k < lo_len; k++)
                step(1'b0, (k == 0) ? p : 8'($urandom),
                     1'($urandom_range(0, 1)));
            for (int k = 0; k < hi_len; k++)
                step(1'b1, 8'($urandom),
                     1'($urandom_range(0, 1)));
        end
        run(1'b0, 4, 1'b1);

        // reset in the middle of a pulse
        run(1'b1, 3, 1'b1);
        do_reset(1'b1);
        run(1'b1, 4, 1'b1);
        step(1'b0, 8'h01, 1'b0);
        chk("t6_hi", 32'(bus.rec_hi), 32'd4);
        chk("t6_lo", 32'(bus.rec_lo), 32'd0);
        chk("t6_partial", 32'(bus.rec_partial), 32'd1);
        chk("t6_ovf", 32'(bus.ovf), 32'd0);

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
